// File: rtl/mnist_pkg.sv
// Shared types and sizing for the MNIST epoch controller.
// Holds the FSM state encoding, default image counts and the interface widths.
package mnist_pkg;

    localparam int unsigned TRAIN_N_DEF = 60000;
    localparam int unsigned TEST_N_DEF  = 2000;
    localparam int unsigned TRAIN_AW    = 16;
    localparam int unsigned TEST_AW     = 11;
    localparam int unsigned N_CLASS     = 10;
    localparam int unsigned CNT_W       = 12;
    localparam int unsigned EPOCH_W     = 4;
    localparam int unsigned DRAIN_W     = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_TRAIN_DRAIN,
        S_TEST,
        S_TEST_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mnist_valid_pipe.sv
// Single-bit valid delay line matching the image RAM latency.
// A synchronous clear flushes all in-flight flags in one edge.
module mnist_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mnist_epoch_ctrl.sv
// Epoch sequencer: streams training addresses to the learner, then scores a
// test pass, repeating for EPOCHS passes; abort or completion yields one done pulse.
module mnist_epoch_ctrl
    import mnist_pkg::*;
#(
    parameter int unsigned TRAIN_N = TRAIN_N_DEF,
    parameter int unsigned TEST_N  = TEST_N_DEF,
    parameter int unsigned EPOCHS  = 1,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [3:0]          threshold_cfg,
    input  logic [N_CLASS-1:0]  test_result,
    input  logic [N_CLASS-1:0]  test_label,
    output logic [TRAIN_AW-1:0] train_addr,
    output logic [TEST_AW-1:0]  test_addr,
    output logic                learn_en,
    output logic [3:0]          threshold,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    correct_cnt,
    output logic [EPOCH_W-1:0]  epoch_idx
);

    localparam logic [TRAIN_AW-1:0] TRAIN_LAST = TRAIN_AW'(TRAIN_N - 1);
    localparam logic [TEST_AW-1:0]  TEST_LAST  = TEST_AW'(TEST_N - 1);
    localparam logic [EPOCH_W-1:0]  EPOCH_LAST = EPOCH_W'(EPOCHS - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(RAM_LAT - 1);

    state_t               state, state_n;
    logic [TRAIN_AW-1:0]  train_addr_n;
    logic [TEST_AW-1:0]   test_addr_n;
    logic [3:0]           threshold_n;
    logic [CNT_W-1:0]     correct_cnt_n;
    logic [EPOCH_W-1:0]   epoch_idx_n;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_n;
    logic [CNT_W-1:0]     score, score_n;
    logic                 pipe_clr;
    logic                 score_vld;
    logic                 hit;

    mnist_valid_pipe #(.DEPTH(RAM_LAT)) u_learn_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (pipe_clr),
        .din  (state == S_TRAIN),
        .dout (learn_en)
    );

    mnist_valid_pipe #(.DEPTH(RAM_LAT)) u_score_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (pipe_clr),
        .din  (state == S_TEST),
        .dout (score_vld)
    );

    assign hit  = score_vld && (test_result == test_label);
    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            train_addr  <= '0;
            test_addr   <= '0;
            threshold   <= '0;
            correct_cnt <= '0;
            epoch_idx   <= '0;
            drain_cnt   <= '0;
            score       <= '0;
        end else begin
            state       <= state_n;
            train_addr  <= train_addr_n;
            test_addr   <= test_addr_n;
            threshold   <= threshold_n;
            correct_cnt <= correct_cnt_n;
            epoch_idx   <= epoch_idx_n;
            drain_cnt   <= drain_cnt_n;
            score       <= score_n;
        end
    end

    always_comb begin
        state_n       = state;
        train_addr_n  = train_addr;
        test_addr_n   = test_addr;
        threshold_n   = threshold;
        correct_cnt_n = correct_cnt;
        epoch_idx_n   = epoch_idx;
        drain_cnt_n   = drain_cnt;
        score_n       = score + CNT_W'(hit);
        pipe_clr      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n      = S_TRAIN;
                    threshold_n  = threshold_cfg;
                    epoch_idx_n  = '0;
                    train_addr_n = '0;
                    test_addr_n  = '0;
                    drain_cnt_n  = '0;
                end
            end

            S_TRAIN: begin
                if (abort) begin
                    state_n  = S_DONE;
                    pipe_clr = 1'b1;
                end else if (train_addr == TRAIN_LAST) begin
                    state_n      = S_TRAIN_DRAIN;
                    train_addr_n = '0;
                    drain_cnt_n  = '0;
                end else begin
                    train_addr_n = train_addr + 1'b1;
                end
            end

            S_TRAIN_DRAIN: begin
                if (abort) begin
                    state_n  = S_DONE;
                    pipe_clr = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_n     = S_TEST;
                    test_addr_n = '0;
                    score_n     = '0;
                end else begin
                    drain_cnt_n = drain_cnt + 1'b1;
                end
            end

            S_TEST: begin
                if (abort) begin
                    state_n  = S_DONE;
                    pipe_clr = 1'b1;
                end else if (test_addr == TEST_LAST) begin
                    state_n     = S_TEST_DRAIN;
                    test_addr_n = '0;
                    drain_cnt_n = '0;
                end else begin
                    test_addr_n = test_addr + 1'b1;
                end
            end

            S_TEST_DRAIN: begin
                if (abort) begin
                    state_n  = S_DONE;
                    pipe_clr = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    // score_n already includes a hit landing on this final drain cycle
                    correct_cnt_n = score_n;
                    drain_cnt_n   = '0;
                    if (epoch_idx == EPOCH_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n     = S_TRAIN;
                        epoch_idx_n = epoch_idx + 1'b1;
                    end
                end else begin
                    drain_cnt_n = drain_cnt + 1'b1;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mnist_epoch_ctrl.sv
// Bench for mnist_epoch_ctrl: two instances (short single-epoch, latency-3 multi-epoch)
// checked each cycle against a timeline model derived from image counts and RAM latency.
module tb_mnist_epoch_ctrl;

    localparam int A_TRN = 4, A_TST = 3, A_EP = 1, A_LAT = 1;
    localparam int B_TRN = 4, B_TST = 5, B_EP = 3, B_LAT = 3;

    logic clk, rst_n, start, abort, sel;
    logic [3:0] cfg;

    logic        a_start, a_abort, b_start, b_abort;
    logic [9:0]  a_res, a_lab, b_res, b_lab;
    logic [15:0] a_ta, b_ta;
    logic [10:0] a_te, b_te;
    logic        a_le, b_le, a_busy, b_busy, a_done, b_done;
    logic [3:0]  a_thr, b_thr, a_ep, b_ep;
    logic [11:0] a_cc, b_cc;

    logic [15:0] o_ta;
    logic [10:0] o_te;
    logic        o_le, o_busy, o_done;
    logic [3:0]  o_thr, o_ep;
    logic [11:0] o_cc;

    int checks = 0;
    int failures = 0;
    int a_dn = 0, b_dn = 0;
    int last_cnt [2];
    logic [9:0] lab_tab [4][8];
    logic [9:0] res_tab [4][8];
    int score_e [4];

    logic [10:0] a_ap [A_LAT];
    logic [10:0] b_ap [B_LAT];

    assign a_start = start & ~sel;
    assign a_abort = abort & ~sel;
    assign b_start = start & sel;
    assign b_abort = abort & sel;

    mnist_epoch_ctrl #(.TRAIN_N(A_TRN), .TEST_N(A_TST), .EPOCHS(A_EP), .RAM_LAT(A_LAT)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .threshold_cfg(cfg),
        .test_result(a_res), .test_label(a_lab), .train_addr(a_ta), .test_addr(a_te),
        .learn_en(a_le), .threshold(a_thr), .busy(a_busy), .done(a_done),
        .correct_cnt(a_cc), .epoch_idx(a_ep)
    );

    mnist_epoch_ctrl #(.TRAIN_N(B_TRN), .TEST_N(B_TST), .EPOCHS(B_EP), .RAM_LAT(B_LAT)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .threshold_cfg(cfg),
        .test_result(b_res), .test_label(b_lab), .train_addr(b_ta), .test_addr(b_te),
        .learn_en(b_le), .threshold(b_thr), .busy(b_busy), .done(b_done),
        .correct_cnt(b_cc), .epoch_idx(b_ep)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Image RAM models: data for an address appears LAT cycles after it is issued.
    always @(posedge clk) begin
        a_ap[0] <= a_te;
        for (int k = 1; k < A_LAT; k++) a_ap[k] <= a_ap[k-1];
        b_ap[0] <= b_te;
        for (int k = 1; k < B_LAT; k++) b_ap[k] <= b_ap[k-1];
        if (a_done) a_dn++;
        if (b_done) b_dn++;
    end

    assign a_res = res_tab[a_ep[1:0]][a_ap[A_LAT-1][2:0]];
    assign a_lab = lab_tab[a_ep[1:0]][a_ap[A_LAT-1][2:0]];
    assign b_res = res_tab[b_ep[1:0]][b_ap[B_LAT-1][2:0]];
    assign b_lab = lab_tab[b_ep[1:0]][b_ap[B_LAT-1][2:0]];

    assign o_ta   = sel ? b_ta   : a_ta;
    assign o_te   = sel ? b_te   : a_te;
    assign o_le   = sel ? b_le   : a_le;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_thr  = sel ? b_thr  : a_thr;
    assign o_ep   = sel ? b_ep   : a_ep;
    assign o_cc   = sel ? b_cc   : a_cc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s sel=%0d t=%0t observed=%0d expected=%0d", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_train_addr"}, 32'(o_ta), 0);
        chk({pfx, "_test_addr"}, 32'(o_te), 0);
        chk({pfx, "_learn_en"}, 32'(o_le), 0);
        chk({pfx, "_threshold"}, 32'(o_thr), 0);
        chk({pfx, "_busy"}, 32'(o_busy), 0);
        chk({pfx, "_done"}, 32'(o_done), 0);
        chk({pfx, "_correct_cnt"}, 32'(o_cc), 0);
        chk({pfx, "_epoch_idx"}, 32'(o_ep), 0);
    endtask

    // mask < 0: random hit pattern; otherwise bit i decides whether test sample i matches.
    task automatic run(input bit s, input int mask, input bit abort_with_start,
                       input int abort_at, input int rst_at);
        int tn, ten, ep, lat, len, total, e, r, t0, cur, dn0;
        logic [3:0] thr;
        logic [9:0] lab;
        bit m;
        tn  = s ? B_TRN : A_TRN;
        ten = s ? B_TST : A_TST;
        ep  = s ? B_EP  : A_EP;
        lat = s ? B_LAT : A_LAT;
        len = tn + ten + 2 * lat;
        total = ep * len;
        t0 = tn + lat;
        for (int ei = 0; ei < 4; ei++) begin
            score_e[ei] = 0;
            for (int ai = 0; ai < 8; ai++) begin
                lab = 10'(1) << $urandom_range(9, 0);
                m = (mask < 0) ? 1'($urandom_range(1, 0)) : 1'((mask >> ai) & 1);
                lab_tab[ei][ai] = lab;
                res_tab[ei][ai] = m ? lab : (lab ^ (10'(1) << $urandom_range(9, 0)));
                if (m && ei < ep && ai < ten) score_e[ei]++;
            end
        end
        thr = 4'($urandom_range(15, 1));
        @(negedge clk);
        sel = s;
        cfg = thr;
        start = 1'b1;
        abort = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cfg = ~thr;
        cur = last_cnt[s];
        for (int c = 0; c < total; c++) begin
            e = c / len;
            r = c % len;
            if (r == 0 && e > 0) cur = score_e[e-1];
            chk("train_addr", 32'(o_ta), (r < tn) ? r : 0);
            chk("test_addr", 32'(o_te), (r >= t0 && r < t0 + ten) ? r - t0 : 0);
            chk("learn_en", 32'(o_le), (r >= lat && r < tn + lat) ? 1 : 0);
            chk("epoch_idx", 32'(o_ep), e);
            chk("busy", 32'(o_busy), 1);
            chk("done_early", 32'(o_done), 0);
            chk("correct_cnt_run", 32'(o_cc), cur);
            chk("threshold", 32'(o_thr), 32'(thr));
            if (c == rst_at) begin
                dn0 = s ? b_dn : a_dn;
                rst_n = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                repeat (3) @(negedge clk);
                chk("no_done_after_rst", s ? b_dn : a_dn, dn0);
                chk_reset_vals("held_rst");
                rst_n = 1'b1;
                last_cnt[0] = 0;
                last_cnt[1] = 0;
                return;
            end
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_done", 32'(o_done), 1);
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_learn_en", 32'(o_le), 0);
                chk("abort_correct_cnt", 32'(o_cc), cur);
                last_cnt[s] = cur;
                @(negedge clk);
                chk("abort_done_once", 32'(o_done), 0);
                chk("abort_idle_learn", 32'(o_le), 0);
                return;
            end
            start = (c == 1);
            @(negedge clk);
            start = 1'b0;
        end
        cur = score_e[ep-1];
        chk("end_done", 32'(o_done), 1);
        chk("end_busy", 32'(o_busy), 0);
        chk("end_learn_en", 32'(o_le), 0);
        chk("end_correct_cnt", 32'(o_cc), cur);
        last_cnt[s] = cur;
        @(negedge clk);
        chk("idle_done", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_correct_cnt", 32'(o_cc), cur);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sel = 1'b0;
        cfg = 4'd9;
        last_cnt[0] = 0;
        last_cnt[1] = 0;
        for (int ei = 0; ei < 4; ei++)
            for (int ai = 0; ai < 8; ai++) begin
                lab_tab[ei][ai] = '0;
                res_tab[ei][ai] = 10'h3ff;
            end
        #3;
        chk_reset_vals("reset_a");
        sel = 1'b1;
        #1;
        chk_reset_vals("reset_b");
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed hits on samples 0 and 2, with abort raised alongside start
        run(1'b0, 5, 1'b1, -1, -1);
        chk("directed_cnt", 32'(a_cc), 2);
        for (int i = 0; i < 3; i++) run(1'b0, -1, 1'b0, -1, -1);
        run(1'b0, -1, 1'b0, 2, -1);
        run(1'b0, -1, 1'b0, -1, -1);

        run(1'b1, -1, 1'b0, -1, -1);
        run(1'b1, -1, 1'b0, -1, -1);
        run(1'b1, -1, 1'b0, (B_TRN + B_TST + 2 * B_LAT) + B_TRN + B_LAT + 2, -1);
        run(1'b1, -1, 1'b0, 1, -1);

        run(1'b0, -1, 1'b0, -1, A_TRN + A_LAT + 1);
        run(1'b0, -1, 1'b0, -1, -1);
        run(1'b1, -1, 1'b0, -1, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
